// File: rtl/uart_tx_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fsm_if
// Description : Request/line bundle between the controller logic and the
//               UART transmitter. The master side raises transmit requests
//               and supplies the byte. The slave side drives the serial line
//               and the busy flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_fsm_if;
  logic       tx_start;
  logic [7:0] to_tx;
  logic       tx_out;
  logic       busy;

  modport master (
    output tx_start,
    output to_tx,
    input  tx_out,
    input  busy
  );

  modport slave (
    input  tx_start,
    input  to_tx,
    output tx_out,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fsm.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fsm
// Description : Byte-serial UART transmitter. Each frame has 1 start bit,
//               8 data bits sent LSB first, 1 even-parity bit and 1 stop bit.
//               The line and busy flag are registered. The start bit appears
//               on the edge that accepts the request.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fsm #(
  parameter int CLK_FREQ     = 16000000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_fsm_if.slave tx_if
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [10:0] c_CNT_LAST = 11'(CLKS_PER_BIT - 1);

  state_t      state_q, state_d;
  logic [10:0] cnt_q,   cnt_d;
  logic [2:0]  idx_q,   idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        par_q,   par_d;
  logic        tx_q,    tx_d;
  logic        busy_q,  busy_d;

  logic        w_bit_done;
  logic [2:0]  w_idx_nxt;

  assign w_bit_done = (cnt_q == c_CNT_LAST);
  assign w_idx_nxt  = idx_q + 3'd1;

  assign tx_if.tx_out = tx_q;
  assign tx_if.busy   = busy_q;

  // State and datapath registers. Reset aborts any frame and idles the line high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 11'd0;
      idx_q   <= 3'd0;
      shreg_q <= 8'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic. tx_d holds the line value for the next cycle, so the
  // registered line changes on the same edge as the state transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;

    case (state_q)
      IDLE: begin
        cnt_d  = 11'd0;
        idx_d  = 3'd0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_if.tx_start) begin
          state_d = START;
          shreg_d = tx_if.to_tx;
          par_d   = 1'b0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      START: begin
        if (w_bit_done) begin
          cnt_d   = 11'd0;
          idx_d   = 3'd0;
          state_d = DATA;
          tx_d    = shreg_q[0];
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end

      DATA: begin
        if (w_bit_done) begin
          cnt_d = 11'd0;
          // Parity accumulates each data bit as that bit finishes.
          par_d = par_q ^ shreg_q[idx_q];
          if (idx_q == 3'd7) begin
            state_d = PARITY;
            tx_d    = par_q ^ shreg_q[7];
          end else begin
            idx_d = w_idx_nxt;
            tx_d  = shreg_q[w_idx_nxt];
          end
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end

      PARITY: begin
        if (w_bit_done) begin
          cnt_d   = 11'd0;
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end

      STOP: begin
        if (w_bit_done) begin
          cnt_d   = 11'd0;
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 11'd0;
        idx_d   = 3'd0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fsm
// Description : Self-checking bench for uart_tx_fsm. Expected line bits are
//               queued when a byte is requested and compared cycle by cycle
//               while the frame is on the line.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fsm;

  localparam int CPB   = 16;
  localparam int FRAME = 11 * CPB;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  logic exp_q[$];

  uart_tx_fsm_if tif ();

  uart_tx_fsm #(
    .CLK_FREQ    (16000000),
    .BAUD        (9600),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .tx_if(tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the expected line sequence of one frame: start, d0..d7, parity, stop.
  task automatic push_frame(input logic [7:0] b);
    logic p;
    p = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(b[i]);
      p = p ^ b[i];
    end
    exp_q.push_back(p);
    exp_q.push_back(1'b1);
  endtask

  // Called just after the accepting edge. Checks every cycle of every bit
  // against the queued values, the busy duration and the return to idle.
  task automatic run_frame(input string name, input int poke_at, input int change_at,
                           input logic [7:0] change_val, input bit keep_start);
    int   cyc;
    int   busy_cnt;
    logic exp;
    logic seen;
    bit   bad;
    cyc      = 0;
    busy_cnt = 0;
    if (!keep_start) tif.tx_start = 1'b0;
    for (int n = 0; n < 11; n++) begin
      exp  = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      bad  = 1'b0;
      seen = exp;
      for (int c = 0; c < CPB; c++) begin
        if (tif.busy === 1'b1) busy_cnt++;
        if ((tif.tx_out !== exp) && !bad) begin
          bad  = 1'b1;
          seen = tif.tx_out;
        end
        if (cyc == poke_at) tif.tx_start = 1'b1;
        else if ((poke_at >= 0) && (cyc == poke_at + 1)) tif.tx_start = 1'b0;
        if (cyc == change_at) tif.to_tx = change_val;
        tick();
        cyc++;
      end
      compared++;
      if (bad) begin
        mismatched++;
        $display("FAIL %s bit%0d: line=%b required=%b for all %0d cycles", name, n, seen, exp, CPB);
      end
    end
    compared++;
    if (busy_cnt != FRAME) begin
      mismatched++;
      $display("FAIL %s busy_len: got=%0d required=%0d", name, busy_cnt, FRAME);
    end
    compared++;
    if ((tif.busy !== 1'b0) || (tif.tx_out !== 1'b1)) begin
      mismatched++;
      $display("FAIL %s end: busy=%b tx_out=%b required busy=0 tx_out=1", name, tif.busy, tif.tx_out);
    end
  endtask

  // Line must sit idle (high, not busy) for the given number of cycles.
  task automatic check_idle(input string name, input int cycles);
    bit bad;
    bad = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if ((tif.busy !== 1'b0) || (tif.tx_out !== 1'b1)) bad = 1'b1;
      tick();
    end
    compared++;
    if (bad) begin
      mismatched++;
      $display("FAIL %s idle: busy=%b tx_out=%b required busy=0 tx_out=1", name, tif.busy, tif.tx_out);
    end
  endtask

  task automatic start_byte(input logic [7:0] b);
    tif.to_tx    = b;
    tif.tx_start = 1'b1;
    push_frame(b);
    tick();
  endtask

  task automatic test_reset();
    rst          = 1'b0;
    tif.tx_start = 1'b0;
    tif.to_tx    = 8'h00;
    repeat (3) tick();
    compared++;
    if ((tif.busy !== 1'b0) || (tif.tx_out !== 1'b1)) begin
      mismatched++;
      $display("FAIL reset_hold: busy=%b tx_out=%b required busy=0 tx_out=1", tif.busy, tif.tx_out);
    end
    rst = 1'b1;
    check_idle("reset_release", 8);
  endtask

  task automatic test_basic();
    start_byte(8'h55);
    run_frame("byte55", -1, -1, 8'h00, 1'b0);
    check_idle("after55", 2);
  endtask

  // tx_start held high: AA then F0 with one idle cycle between frames.
  task automatic test_back_to_back();
    start_byte(8'hAA);
    push_frame(8'hF0);
    run_frame("byteAA", -1, 4 * CPB, 8'hF0, 1'b1);
    tick();
    compared++;
    if ((tif.busy !== 1'b1) || (tif.tx_out !== 1'b0)) begin
      mismatched++;
      $display("FAIL b2b_restart: busy=%b tx_out=%b required busy=1 tx_out=0", tif.busy, tif.tx_out);
    end
    run_frame("byteF0", -1, -1, 8'h00, 1'b0);
    check_idle("afterF0", 2);
  endtask

  task automatic test_parity_integrity();
    start_byte(8'h07);
    run_frame("byte07", -1, 2 * CPB + 3, 8'h00, 1'b0);
    check_idle("after07", 2);
  endtask

  task automatic test_ignore_start();
    start_byte(8'h55);
    run_frame("poke55", 5 * CPB + 3, -1, 8'h00, 1'b0);
    check_idle("no_second_frame", 3 * CPB);
  endtask

  task automatic test_reset_mid_frame();
    tif.to_tx    = 8'hC3;
    tif.tx_start = 1'b1;
    tick();
    tif.tx_start = 1'b0;
    repeat (3 * CPB + 5) tick();
    rst = 1'b0;
    tick();
    compared++;
    if ((tif.busy !== 1'b0) || (tif.tx_out !== 1'b1)) begin
      mismatched++;
      $display("FAIL reset_abort: busy=%b tx_out=%b required busy=0 tx_out=1", tif.busy, tif.tx_out);
    end
    rst = 1'b1;
    check_idle("post_abort", 4);
    start_byte(8'h3C);
    run_frame("byte3C", -1, -1, 8'h00, 1'b0);
  endtask

  task automatic test_reset_vs_start();
    tif.to_tx    = 8'hFF;
    tif.tx_start = 1'b1;
    rst          = 1'b0;
    tick();
    tif.tx_start = 1'b0;
    rst          = 1'b1;
    compared++;
    if ((tif.busy !== 1'b0) || (tif.tx_out !== 1'b1)) begin
      mismatched++;
      $display("FAIL reset_wins: busy=%b tx_out=%b required busy=0 tx_out=1", tif.busy, tif.tx_out);
    end
    check_idle("reset_wins_idle", 2 * CPB);
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    rst          = 1'b0;
    tif.tx_start = 1'b0;
    tif.to_tx    = 8'h00;
    test_reset();
    test_basic();
    test_back_to_back();
    test_parity_integrity();
    test_ignore_start();
    test_reset_mid_frame();
    test_reset_vs_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_fsm.md
# uart_tx_fsm

Byte-serial UART transmitter. It serialises one 8-bit word per request into a standard asynchronous frame: 1 start bit, 8 data bits LSB first, 1 even-parity bit and 1 stop bit. It sits between the on-chip controller logic and the board-level TX pin, and reports `busy` to the requester. The default configuration targets a 16 MHz system clock at 9600 baud.

## Interface
Parameters:
- `CLK_FREQ`, default 16000000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s.
- `CLKS_PER_BIT`, default (CLK_FREQ + BAUD/2)/BAUD = 1667: clock cycles per bit. Derived, overridable. Must satisfy 2 ≤ value ≤ 2047.

Ports:
- `clk`, input, 1: system clock; all logic on the rising edge.
- `rst`, input, 1: reset. One clock; reset is synchronous and active-low (asserted when 0, sampled on the `clk` rising edge).
- `tx_start`, input, 1: transmit request, sampled only in IDLE. One cycle high is sufficient.
- `to_tx`, input, 8: byte to send, captured on the edge that accepts `tx_start`.
- `tx_out`, output, 1: serial line. Idles high. Registered.
- `busy`, output, 1: high while a frame is in progress. Registered.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. The state, an 11-bit baud counter, a 3-bit bit index, an 8-bit shift/hold register and a parity accumulator are all registered.
- Reset (rst=0 at an edge):
  - state → IDLE, `tx_out` → 1, `busy` → 0, counters → 0.
  - Reset overrides everything, including a frame in progress; the line returns high immediately with no stop bit.
- IDLE:
  - `tx_out`=1, `busy`=0.
  - If `tx_start`=1, latch `to_tx`, go to START, drive `tx_out`=0 and `busy`=1.
- START: hold 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - `tx_out` = latched bit[index], each held for CLKS_PER_BIT cycles.
  - After index 7, go to PARITY.
- PARITY: `tx_out` = XOR of the 8 latched bits (even parity: the total count of ones over data plus parity is even), held CLKS_PER_BIT cycles.
- STOP: `tx_out`=1 for CLKS_PER_BIT cycles, then go to IDLE with `busy`=0.
- Data integrity:
  - `tx_start` is ignored while not in IDLE.
  - Changes on `to_tx` after capture do not affect the frame in flight.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 within each bit and wraps to 0 on the bit transition.
  - It is the only timebase; there is no fractional-baud accumulation.

## Timing
- Let edge k be the rising edge at which IDLE samples `tx_start`=1 (with `rst`=1).
- Immediately after edge k: `busy`=1 and `tx_out`=0 (start bit). Zero-cycle latency from acceptance to line activity.
- Bit n (n=0 start, 1..8 data d0..d7, 9 parity, 10 stop) occupies edges k+n·CLKS_PER_BIT up to, but not including, k+(n+1)·CLKS_PER_BIT.
- Frame length is 11·CLKS_PER_BIT = 18337 cycles, 1.146 ms at default parameters.
- At edge k+18337: state → IDLE, `busy` → 0, `tx_out` stays 1.
- The earliest next acceptance is edge k+18338. The STOP→IDLE edge does not itself sample `tx_start`.
- `tx_start` held high continuously produces back-to-back frames separated by 1 idle cycle.
- `tx_start` and `rst`=0 at the same edge: reset wins and nothing is latched.

## Test plan
- Reset: hold `rst`=0 for 3 cycles, then release → `tx_out`=1, `busy`=0, and they stay so with `tx_start`=0.
- Send 8'h55 with a one-cycle pulse → line reads 0,1,0,1,0,1,0,1,0,0,1 (start, d0..d7, parity=0, stop), each bit exactly 1667 cycles; `busy` high for exactly 18337 cycles.
- After IDLE is reached, send 8'hAA and then 8'hF0 → bits 0,0,1,0,1,0,1,0,1,0,1 and 0,0,0,0,0,1,1,1,1,0,1 respectively.
- Send 8'h07 (odd count of ones) → parity bit 1. Change `to_tx` to 8'h00 mid-frame → the frame is unchanged.
- Pulse `tx_start` again at cycle 5000 of an active frame → ignored; `busy` falls exactly at 18337, and no second frame follows.
- Assert `rst`=0 during DATA → `tx_out`=1 and `busy`=0 one edge later. A new `tx_start` after release sends a complete, correct frame.
